// File: rtl/matmul_feeder_if.sv
// Handshake and data bundle between a job source, the matmul feeder and the downstream multiplier.
// The feeder connects through the slave modport; the producer or testbench uses the master modport.
interface matmul_feeder_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [63:0] cfg_dims_a;
  logic [63:0] cfg_dims_b;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_data;
  logic        abort;
  logic        mm_start;
  logic [63:0] mm_dims_a;
  logic [63:0] mm_dims_b;
  logic [31:0] mm_in_a;
  logic [31:0] mm_in_b;
  logic        busy;
  logic        done;
  logic        err;

  modport slave (
    input  cfg_valid, cfg_dims_a, cfg_dims_b,
    input  a_valid, a_data, b_valid, b_data, abort,
    output cfg_ready, a_ready, b_ready,
    output mm_start, mm_dims_a, mm_dims_b, mm_in_a, mm_in_b,
    output busy, done, err
  );

  modport master (
    output cfg_valid, cfg_dims_a, cfg_dims_b,
    output a_valid, a_data, b_valid, b_data, abort,
    input  cfg_ready, a_ready, b_ready,
    input  mm_start, mm_dims_a, mm_dims_b, mm_in_a, mm_in_b,
    input  busy, done, err
  );
endinterface

// File: rtl/matmul_feeder.sv
// Buffers two row-major operand matrices, then pulses mm_start and streams both buffers
// element by element to a downstream multiplier, zero-padding the shorter operand.
module matmul_feeder #(
  parameter int BUF_SIZE = 1024
) (
  input logic           clk,
  input logic           rst_n,
  matmul_feeder_if.slave feed
);

  localparam int AW = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
  localparam int CW = $clog2(BUF_SIZE + 1);
  localparam logic [63:0] BUF_LIMIT = 64'(BUF_SIZE);

  typedef enum logic [1:0] {IDLE, LOAD, START, STREAM} state_t;

  state_t        state_q, state_d;
  logic [63:0]   dimsA_q, dimsA_d, dimsB_q, dimsB_d;
  logic [CW-1:0] cntA_q, cntA_d, cntB_q, cntB_d;
  logic [CW-1:0] idxA_q, idxA_d, idxB_q, idxB_d;
  logic [CW-1:0] rdIdx_q, rdIdx_d, nMax;
  logic [AW-1:0] rdAddr;
  logic          err_q, err_d, done_q, done_d;
  logic          cfgEn_q;

  logic [31:0]   bufA [BUF_SIZE];
  logic [31:0]   bufB [BUF_SIZE];
  logic [31:0]   rdA_q, rdB_q;

  logic signed [31:0] rowsA, colsA, rowsB, colsB;
  logic [63:0]   prodA, prodB;
  logic          descOk, cfgReady, cfgFire;
  logic          aReady, bReady, aFire, bFire;

  assign rowsA = feed.cfg_dims_a[63:32];
  assign colsA = feed.cfg_dims_a[31:0];
  assign rowsB = feed.cfg_dims_b[63:32];
  assign colsB = feed.cfg_dims_b[31:0];

  // Zero-extended 64-bit products cannot wrap; negative dims are rejected by the sign tests anyway.
  assign prodA = {32'd0, feed.cfg_dims_a[63:32]} * {32'd0, feed.cfg_dims_a[31:0]};
  assign prodB = {32'd0, feed.cfg_dims_b[63:32]} * {32'd0, feed.cfg_dims_b[31:0]};

  assign descOk = (rowsA > 0) && (colsA > 0) && (rowsB > 0) && (colsB > 0) &&
                  (colsA == rowsB) && (prodA <= BUF_LIMIT) && (prodB <= BUF_LIMIT);

  assign cfgReady = (state_q == IDLE) && cfgEn_q;
  assign cfgFire  = feed.cfg_valid && cfgReady;
  assign aReady   = (state_q == LOAD) && (idxA_q < cntA_q);
  assign bReady   = (state_q == LOAD) && (idxB_q < cntB_q);
  assign aFire    = feed.a_valid && aReady;
  assign bFire    = feed.b_valid && bReady;
  assign nMax     = (cntA_q > cntB_q) ? cntA_q : cntB_q;

  // START reads element 0 so the first STREAM cycle already has registered data.
  assign rdAddr = (state_q == STREAM) ? AW'(rdIdx_q + CW'(1)) : '0;

  always_comb begin
    state_d = state_q;
    dimsA_d = dimsA_q;
    dimsB_d = dimsB_q;
    cntA_d  = cntA_q;
    cntB_d  = cntB_q;
    idxA_d  = idxA_q;
    idxB_d  = idxB_q;
    rdIdx_d = rdIdx_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfgFire) begin
          if (descOk) begin
            dimsA_d = feed.cfg_dims_a;
            dimsB_d = feed.cfg_dims_b;
            cntA_d  = prodA[CW-1:0];
            cntB_d  = prodB[CW-1:0];
            idxA_d  = '0;
            idxB_d  = '0;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (feed.abort) begin
          state_d = IDLE;
        end else begin
          idxA_d = idxA_q + CW'(aFire);
          idxB_d = idxB_q + CW'(bFire);
          if ((idxA_d == cntA_q) && (idxB_d == cntB_q)) begin
            state_d = START;
          end
        end
      end
      START: begin
        if (feed.abort) begin
          state_d = IDLE;
        end else begin
          rdIdx_d = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (feed.abort) begin
          state_d = IDLE;
        end else if (rdIdx_q == nMax - CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          rdIdx_d = rdIdx_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dimsA_q <= '0;
      dimsB_q <= '0;
      cntA_q  <= '0;
      cntB_q  <= '0;
      idxA_q  <= '0;
      idxB_q  <= '0;
      rdIdx_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      cfgEn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dimsA_q <= dimsA_d;
      dimsB_q <= dimsB_d;
      cntA_q  <= cntA_d;
      cntB_q  <= cntB_d;
      idxA_q  <= idxA_d;
      idxB_q  <= idxB_d;
      rdIdx_q <= rdIdx_d;
      err_q   <= err_d;
      done_q  <= done_d;
      cfgEn_q <= 1'b1;
    end
  end

  // Operand storage keeps its contents across reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (aFire) bufA[idxA_q[AW-1:0]] <= feed.a_data;
    if (bFire) bufB[idxB_q[AW-1:0]] <= feed.b_data;
    rdA_q <= bufA[rdAddr];
    rdB_q <= bufB[rdAddr];
  end

  assign feed.cfg_ready = cfgReady;
  assign feed.a_ready   = aReady;
  assign feed.b_ready   = bReady;
  assign feed.mm_start  = (state_q == START) && !feed.abort;
  assign feed.mm_dims_a = dimsA_q;
  assign feed.mm_dims_b = dimsB_q;
  assign feed.mm_in_a   = ((state_q == STREAM) && (rdIdx_q < cntA_q)) ? rdA_q : '0;
  assign feed.mm_in_b   = ((state_q == STREAM) && (rdIdx_q < cntB_q)) ? rdB_q : '0;
  assign feed.busy      = (state_q != IDLE);
  assign feed.done      = done_q;
  assign feed.err       = err_q;

endmodule

// File: tb/tb_matmul_feeder.sv
// Self-checking bench for matmul_feeder: descriptor validation table, randomized load/stream
// jobs checked against expected streams built from the operand data, plus abort and reset cases.
module tb_matmul_feeder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nChecks = 0;
  int   nFails  = 0;

  matmul_feeder_if feed();

  matmul_feeder #(.BUF_SIZE(1024)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .feed (feed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ra;
    int ca;
    int rb;
    int cb;
    bit expErr;
  } descVec_t;

  descVec_t descTable[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one complete job; resetAt > 0 pulses rst_n in that stream cycle and abandons the job.
  task automatic applyStimulus(input int ra, input int ca, input int rb, input int cb,
                               input int gapPct, input bit syncLast,
                               input int aBase, input int bBase, input int resetAt);
    int cntA, cntB, n, sentA, sentB, lastA, lastB, startCyc, starts, doneCyc, budget, k;
    bit leak, finalBoth, goA, goB;
    logic [31:0] aData[$];
    logic [31:0] bData[$];
    logic [31:0] expA, expB;
    cntA = ra * ca;
    cntB = rb * cb;
    n = (cntA > cntB) ? cntA : cntB;
    sentA = 0; sentB = 0; lastA = -1; lastB = -1;
    startCyc = -1; starts = 0; doneCyc = -1; leak = 1'b0;
    for (int i = 0; i < cntA; i++) aData.push_back((aBase != 0) ? 32'(aBase + i) : $urandom);
    for (int i = 0; i < cntB; i++) bData.push_back((bBase != 0) ? 32'(bBase + i) : $urandom);

    @(negedge clk);
    feed.cfg_valid  = 1'b1;
    feed.cfg_dims_a = {ra[31:0], ca[31:0]};
    feed.cfg_dims_b = {rb[31:0], cb[31:0]};
    @(negedge clk);
    feed.cfg_valid = 1'b0;
    checkOutput("busy after cfg", 64'(feed.busy), 64'd1);

    budget = 30 * (cntA + cntB) + n + 20;
    for (int cyc = 0; cyc < budget && doneCyc < 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (feed.mm_start) begin
        starts++;
        if (startCyc < 0) begin
          startCyc = cyc;
          checkOutput("mm_dims_a", feed.mm_dims_a, {ra[31:0], ca[31:0]});
          checkOutput("mm_dims_b", feed.mm_dims_b, {rb[31:0], cb[31:0]});
          checkOutput("mm_in_a at start", 64'(feed.mm_in_a), 64'd0);
        end
      end
      if (startCyc >= 0 && cyc > startCyc && cyc <= startCyc + n) begin
        k = cyc - startCyc;
        expA = (k - 1 < cntA) ? aData[k-1] : 32'd0;
        expB = (k - 1 < cntB) ? bData[k-1] : 32'd0;
        checkOutput($sformatf("mm_in_a[%0d]", k), 64'(feed.mm_in_a), 64'(expA));
        checkOutput($sformatf("mm_in_b[%0d]", k), 64'(feed.mm_in_b), 64'(expB));
      end
      if (feed.done) begin
        doneCyc = cyc;
        checkOutput("busy at done", 64'(feed.busy), 64'd0);
        checkOutput("mm_in_b after stream", 64'(feed.mm_in_b), 64'd0);
      end
      if (resetAt > 0 && startCyc >= 0 && cyc == startCyc + resetAt) begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset mm_in_a", 64'(feed.mm_in_a), 64'd0);
        checkOutput("reset mm_in_b", 64'(feed.mm_in_b), 64'd0);
        checkOutput("reset busy", 64'(feed.busy), 64'd0);
        checkOutput("reset cfg_ready", 64'(feed.cfg_ready), 64'd0);
        checkOutput("reset mm_dims_a", feed.mm_dims_a, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          checkOutput("no done after reset", 64'(feed.done), 64'd0);
        end
        checkOutput("cfg_ready after reset", 64'(feed.cfg_ready), 64'd1);
        return;
      end
      if (sentA >= cntA && feed.a_ready) leak = 1'b1;
      if (sentB >= cntB && feed.b_ready) leak = 1'b1;
      finalBoth = (sentA >= cntA - 1) && (sentB >= cntB - 1);
      if (syncLast) begin
        goA = (sentA < cntA - 1) ? ($urandom_range(99) >= gapPct) : (sentA == cntA - 1 && finalBoth);
        goB = (sentB < cntB - 1) ? ($urandom_range(99) >= gapPct) : (sentB == cntB - 1 && finalBoth);
      end else begin
        goA = (sentA < cntA) && ($urandom_range(99) >= gapPct);
        goB = (sentB < cntB) && ($urandom_range(99) >= gapPct);
      end
      feed.a_valid = goA;
      feed.a_data  = goA ? aData[sentA] : 32'd0;
      feed.b_valid = goB;
      feed.b_data  = goB ? bData[sentB] : 32'd0;
      if (goA && feed.a_ready) begin sentA++; lastA = cyc; end
      if (goB && feed.b_ready) begin sentB++; lastB = cyc; end
    end
    feed.a_valid = 1'b0;
    feed.b_valid = 1'b0;

    checkOutput("single mm_start", 64'(starts), 64'd1);
    checkOutput("start timing", 64'(startCyc), 64'(((lastA > lastB) ? lastA : lastB) + 1));
    checkOutput("done timing", 64'(doneCyc), 64'(startCyc + n + 1));
    checkOutput("ready after last element", 64'(leak), 64'd0);
    if (syncLast) checkOutput("last A/B same cycle", 64'(lastA), 64'(lastB));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent;
    feed.cfg_valid = 1'b0; feed.cfg_dims_a = '0; feed.cfg_dims_b = '0;
    feed.a_valid = 1'b0; feed.a_data = '0;
    feed.b_valid = 1'b0; feed.b_data = '0;
    feed.abort = 1'b0;

    #1;
    checkOutput("reset cfg_ready", 64'(feed.cfg_ready), 64'd0);
    checkOutput("reset busy", 64'(feed.busy), 64'd0);
    checkOutput("reset mm_dims_b", feed.mm_dims_b, 64'd0);
    checkOutput("reset status", {61'd0, feed.err, feed.done, feed.mm_start}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("cfg_ready before first edge", 64'(feed.cfg_ready), 64'd0);
    @(negedge clk);
    checkOutput("cfg_ready after release", 64'(feed.cfg_ready), 64'd1);

    descTable.push_back('{2, 3, 2, 2, 1'b1});
    descTable.push_back('{0, 3, 3, 2, 1'b1});
    descTable.push_back('{2, 3, 3, 0, 1'b1});
    descTable.push_back('{33, 32, 32, 1, 1'b1});
    descTable.push_back('{32, 32, 32, 1, 1'b0});
    descTable.push_back('{-1, 3, 3, 2, 1'b1});
    descTable.push_back('{-2, -3, -3, 2, 1'b1});
    descTable.push_back('{2, 3, 3, 2, 1'b0});
    descTable.push_back('{1, 1024, 1024, 1, 1'b0});
    descTable.push_back('{1, 1025, 1025, 1, 1'b1});
    descTable.push_back('{65536, 65536, 65536, 1, 1'b1});

    foreach (descTable[i]) begin
      @(negedge clk);
      checkOutput("cfg_ready idle", 64'(feed.cfg_ready), 64'd1);
      feed.cfg_valid  = 1'b1;
      feed.cfg_dims_a = {descTable[i].ra, descTable[i].ca};
      feed.cfg_dims_b = {descTable[i].rb, descTable[i].cb};
      @(negedge clk);
      feed.cfg_valid = 1'b0;
      checkOutput($sformatf("err desc%0d", i), 64'(feed.err), 64'(descTable[i].expErr));
      checkOutput($sformatf("busy desc%0d", i), 64'(feed.busy), 64'(!descTable[i].expErr));
      checkOutput($sformatf("cfg_ready desc%0d", i), 64'(feed.cfg_ready), 64'(descTable[i].expErr));
      @(negedge clk);
      checkOutput("err one cycle", 64'(feed.err), 64'd0);
      if (!descTable[i].expErr) begin
        feed.abort = 1'b1;
        @(negedge clk);
        feed.abort = 1'b0;
        checkOutput("busy after abort", 64'(feed.busy), 64'd0);
      end
    end

    applyStimulus(2, 3, 3, 2, 0, 1'b0, 1, 7, 0);
    applyStimulus(2, 1, 1, 3, 0, 1'b0, 5, 1, 0);
    applyStimulus(4, 4, 4, 4, 40, 1'b1, 0, 0, 0);
    applyStimulus(3, 5, 5, 2, 30, 1'b0, 0, 0, 0);

    // Abort partway through loading A.
    @(negedge clk);
    feed.cfg_valid  = 1'b1;
    feed.cfg_dims_a = {32'd4, 32'd4};
    feed.cfg_dims_b = {32'd4, 32'd4};
    @(negedge clk);
    feed.cfg_valid = 1'b0;
    sent = 0;
    for (int c = 0; c < 20 && sent < 3; c++) begin
      feed.a_valid = 1'b1;
      feed.a_data  = $urandom;
      if (feed.a_ready) sent++;
      @(negedge clk);
    end
    feed.a_valid = 1'b0;
    checkOutput("abort prefill count", 64'(sent), 64'd3);
    checkOutput("busy before abort", 64'(feed.busy), 64'd1);
    feed.abort = 1'b1;
    @(negedge clk);
    feed.abort = 1'b0;
    checkOutput("busy after abort", 64'(feed.busy), 64'd0);
    checkOutput("no mm_start after abort", 64'(feed.mm_start), 64'd0);
    @(negedge clk);
    checkOutput("quiet after abort", {61'd0, feed.err, feed.done, feed.mm_start}, 64'd0);
    applyStimulus(4, 4, 4, 4, 25, 1'b0, 0, 0, 0);

    for (int r = 0; r < 3; r++) begin
      applyStimulus(int'($urandom_range(1, 6)), 3, 3, int'($urandom_range(1, 6)),
                    int'($urandom_range(0, 50)), 1'b0, 0, 0, 0);
    end

    applyStimulus(2, 3, 3, 2, 0, 1'b0, 1, 7, 3);
    applyStimulus(2, 3, 3, 2, 0, 1'b0, 1, 7, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
